mask_erode_stream: RTL
======================

Name: mask_erode_stream

Overview:
- Streaming 3x3 binary erosion on the skin mask produced by the face reader's SEND_DATA raster stream.
- Removes isolated skin pixels and thin noise before centroid accumulation.
- Consumes one mask pixel per accepted beat in raster order and emits an eroded mask pixel with its (x,y) coordinates.
- Uses two internal 1-bit line buffers; no full-frame storage.

Parameters:
WIDTH, 256, pixels per row (2..511)
DEPTH, 256, rows per frame (2..511)
COLOR_DEPTH, 8, bits per mask pixel in and out

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame when idle
pix_in  in  COLOR_DEPTH  mask pixel; nonzero = white
pix_valid  in  1  pix_in is valid this cycle
pix_out  out  COLOR_DEPTH  eroded pixel: all-ones (white) or 0
out_valid  out  1  pix_out/out_x/out_y valid this cycle
out_x  out  9  column of pix_out
out_y  out  9  row of pix_out
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse after last output pixel

Behaviour:
- Reset (async, rst_n=0): state IDLE; pix_out=0, out_valid=0, out_x=0, out_y=0, busy=0, frame_done=0; input counter, output counter, window and line-buffer read pointers cleared. Line-buffer contents need no clearing.
- Binarisation: b = (pix_in != 0).
- Erosion: interior pixel (1<=x<=WIDTH-2, 1<=y<=DEPTH-2) is white iff all 9 neighbours are white. Border pixels (x=0, x=WIDTH-1, y=0, y=DEPTH-1) always output 0.
- White output = {COLOR_DEPTH{1'b1}} (255 at default).
- States:
  - IDLE: start=1 -> RUN, busy<=1, counters cleared. pix_valid ignored.
  - RUN: each cycle with pix_valid=1 accepts one pixel; input index n increments.
    - Once n >= WIDTH+1, accepting input n produces output index k = n-(WIDTH+1) on the next cycle.
    - After input WIDTH*DEPTH-1 is accepted -> FLUSH.
  - FLUSH: pix_valid ignored. Internally advances one virtual pixel per cycle (value 0) and emits one output per cycle until output index WIDTH*DEPTH-1 is emitted -> DONE.
  - DONE: frame_done=1 for exactly one cycle, busy<=0 -> IDLE.
- Output count: exactly WIDTH*DEPTH out_valid pulses per frame, raster order. out_x/out_y wrap x at WIDTH-1 and increment y.
- Latency: out_valid rises exactly 1 cycle after the (WIDTH+2)th accepted input. In FLUSH, one output per cycle, back-to-back.
- out_valid is a single-cycle qualifier; no backpressure. pix_out/out_x/out_y hold their last values when out_valid=0.
- Input gaps (pix_valid=0 in RUN) stall the pipeline; the output sequence is identical to a gap-free stream.
- start while busy: ignored. start and pix_valid in the same cycle in IDLE: the pixel is not accepted.
- Reset mid-frame: immediate abort to IDLE with reset values. The next start processes a clean frame with no stale window influence, since border/counter logic ignores old line-buffer contents.
- Counters are 9-bit for x/y; the pixel index is wide enough for WIDTH*DEPTH.

Test Plan:
- WIDTH=8, DEPTH=8, all pixels 255 -> 64 out_valid; pix_out=255 only for x,y in 1..6 (36 pixels), 0 elsewhere; frame_done exactly 1 cycle after the 64th out_valid; busy falls with it.
- Same frame, only (4,4)=0 -> outputs at x,y in 3..5 are 0; 27 interior pixels = 255.
- All-black frame except one white pixel at (3,3) -> all 64 outputs 0.
- All-white 8x8 with pix_valid high every other cycle -> identical pix_out/out_x/out_y sequence; first out_valid 1 cycle after the 10th accepted pixel, with out_x=0, out_y=0.
- Assert rst_n=0 after 20 accepted pixels -> out_valid=0, busy=0 immediately. Then start plus the full single-black-pixel frame -> result identical to the single-black-pixel scenario.
- start pulsed while busy mid-frame -> no restart; the frame completes with 64 outputs and one frame_done.

Source files
------------

// File: rtl/mask_erode_stream.sv
// Streaming 3x3 binary erosion of a raster mask using two 1-bit line buffers.
// Latency: an output pixel appears the cycle after input index n >= WIDTH+1 is accepted.
// Backpressure: none; input gaps stall the window, and out_valid is a one-cycle qualifier.
module mask_erode_stream #(
    parameter int WIDTH       = 256,
    parameter int DEPTH       = 256,
    parameter int COLOR_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [COLOR_DEPTH-1:0] pix_in,
    input  logic                   pix_valid,
    output logic [COLOR_DEPTH-1:0] pix_out,
    output logic                   out_valid,
    output logic [8:0]             out_x,
    output logic [8:0]             out_y,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int TOTAL  = WIDTH * DEPTH;
    // Last virtual input index: the flush runs WIDTH+1 zero pixels past the frame.
    localparam int LAST_N = TOTAL + WIDTH;
    localparam int NW     = $clog2(LAST_N + 1);
    localparam int XW     = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [NW-1:0]          n_q;
    logic [XW-1:0]          ix_q;
    logic [5:0]             win_q;      // [5:3] column two back, [2:0] one back; {top,mid,bot}
    logic [8:0]             ox_q, oy_q; // coordinate of the next pixel to emit
    logic [WIDTH-1:0]       lb0_q;      // row y-1
    logic [WIDTH-1:0]       lb1_q;      // row y-2
    logic [COLOR_DEPTH-1:0] pix_out_q;
    logic                   out_valid_q;
    logic [8:0]             out_x_q, out_y_q;
    logic                   busy_q;
    logic                   frame_done_q;

    logic       step;
    logic       bit_in;
    logic [2:0] col_cur;
    logic       emit;
    logic       interior;
    logic       white;

    // Window advance, current column and erosion decision for the pixel about to be emitted.
    always_comb begin
        step     = ((state_q == S_RUN) && pix_valid) || (state_q == S_FLUSH);
        bit_in   = (state_q == S_RUN) && (pix_in != '0);
        col_cur  = {lb1_q[ix_q], lb0_q[ix_q], bit_in};
        emit     = step && (n_q >= NW'(WIDTH + 1));
        // Border pixels are forced black, which also masks stale or wrapped window data.
        interior = (ox_q != 9'd0) && (ox_q != 9'(WIDTH - 1)) &&
                   (oy_q != 9'd0) && (oy_q != 9'(DEPTH - 1));
        white    = interior && (&{win_q, col_cur});
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (pix_valid && (n_q == NW'(TOTAL - 1))) state_d = S_FLUSH;
            S_FLUSH: if (n_q == NW'(LAST_N)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Counters, window shift, output registers and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q          <= '0;
            ix_q         <= '0;
            win_q        <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            pix_out_q    <= '0;
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= emit;
            frame_done_q <= (state_q == S_DONE);
            if (state_q == S_DONE) busy_q <= 1'b0;

            if ((state_q == S_IDLE) && start) begin
                n_q    <= '0;
                ix_q   <= '0;
                win_q  <= '0;
                ox_q   <= '0;
                oy_q   <= '0;
                busy_q <= 1'b1;
            end else if (step) begin
                n_q   <= n_q + 1'b1;
                ix_q  <= (ix_q == XW'(WIDTH - 1)) ? '0 : ix_q + 1'b1;
                win_q <= {win_q[2:0], col_cur};
            end

            if (emit) begin
                pix_out_q <= white ? {COLOR_DEPTH{1'b1}} : '0;
                out_x_q   <= ox_q;
                out_y_q   <= oy_q;
                if (ox_q == 9'(WIDTH - 1)) begin
                    ox_q <= 9'd0;
                    oy_q <= oy_q + 9'd1;
                end else begin
                    ox_q <= ox_q + 9'd1;
                end
            end
        end
    end

    // Line buffers: contents need no reset because border logic never exposes them stale.
    always_ff @(posedge clk) begin
        if (step) begin
            lb1_q[ix_q] <= lb0_q[ix_q];
            lb0_q[ix_q] <= bit_in;
        end
    end

    assign pix_out    = pix_out_q;
    assign out_valid  = out_valid_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
